// File: rtl/khani_pkg.sv
// Shared types and the stable ordering predicate for the khani stream sorter.
package khani_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RANK  = 2'd1,
    PLACE = 2'd2,
    EMIT  = 2'd3
  } khani_state_t;

  // Operands are zero-extended to this width by callers; keys wider than this are not supported.
  localparam int KHANI_CMPW = 32;

  // True when key a (arrival index ia) must be emitted ahead of key b (arrival index ib).
  function automatic logic khani_before(
    input logic [KHANI_CMPW-1:0] a,
    input logic [KHANI_CMPW-1:0] b,
    input logic [KHANI_CMPW-1:0] ia,
    input logic [KHANI_CMPW-1:0] ib,
    input logic                  desc
  );
    logic strict_s;
    logic tie_s;
    strict_s = desc ? (a > b) : (a < b);
    tie_s    = (a == b) && (ia < ib);
    return strict_s | tie_s;
  endfunction

endpackage

// File: rtl/khani_rank_row.sv
// Combinational rank of one selected key against the whole frame: N comparators plus a popcount.
module khani_rank_row
  import khani_pkg::*;
#(
  parameter int N     = 6,
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]          sel_key,
  input  logic [$clog2(N)-1:0]      sel_idx,
  input  logic [N-1:0][WIDTH-1:0]   keys,
  input  logic                      desc,
  output logic [$clog2(N)-1:0]      rank
);

  localparam int IDXW = $clog2(N);

  logic [IDXW-1:0] rank_s;

  // The selected key never precedes itself, so the count tops out at N-1 and fits IDXW bits.
  always_comb begin
    rank_s = '0;
    for (int j = 0; j < N; j++) begin
      rank_s = rank_s + IDXW'(khani_before(KHANI_CMPW'(keys[j]), KHANI_CMPW'(sel_key),
                                           KHANI_CMPW'(j), KHANI_CMPW'(sel_idx), desc));
    end
  end

  assign rank = rank_s;

endmodule

// File: rtl/khani_stream_sorter.sv
// Frame sorter: loads N keys, ranks one per cycle, scatters into sorted order, streams them out
// with their arrival index under valid/ready backpressure.
module khani_stream_sorter
  import khani_pkg::*;
#(
  parameter  int N     = 6,
  parameter  int WIDTH = 8,
  localparam int IDXW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_desc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             busy
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  khani_state_t     state_r;
  logic [IDXW-1:0]  cnt_r;
  logic             desc_r;
  logic [WIDTH-1:0] key_r    [N];
  logic [IDXW-1:0]  rank_r   [N];
  logic [WIDTH-1:0] sorted_r [N];
  logic [IDXW-1:0]  sidx_r   [N];

  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [IDXW-1:0]  out_idx_r;
  logic             out_last_r;
  logic             busy_r;

  logic [N-1:0][WIDTH-1:0] keys_s;
  logic [IDXW-1:0]         rank_s;
  logic [IDXW-1:0]         cnt_nx_s;
  logic [WIDTH-1:0]        first_key_s;
  logic [IDXW-1:0]         first_idx_s;
  logic                    in_fire_s;
  logic                    out_fire_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;
  assign cnt_nx_s   = cnt_r + IDXW'(1);

  // Flatten key storage for the rank row and pick the rank-0 element so the first
  // output beat can be registered in the same cycle the sorted arrays are written.
  always_comb begin
    first_key_s = '0;
    first_idx_s = '0;
    for (int i = 0; i < N; i++) begin
      keys_s[i]   = key_r[i];
      first_key_s = first_key_s | ((rank_r[i] == '0) ? key_r[i] : '0);
      first_idx_s = first_idx_s | ((rank_r[i] == '0) ? IDXW'(i) : '0);
    end
  end

  khani_rank_row #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_rank_row (
    .sel_key (key_r[cnt_r]),
    .sel_idx (cnt_r),
    .keys    (keys_s),
    .desc    (desc_r),
    .rank    (rank_s)
  );

  // Frame FSM with all storage and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= LOAD;
      cnt_r       <= '0;
      desc_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_idx_r   <= '0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        key_r[i]    <= '0;
        rank_r[i]   <= '0;
        sorted_r[i] <= '0;
        sidx_r[i]   <= '0;
      end
    end else begin
      case (state_r)
        LOAD: begin
          if (in_fire_s) begin
            key_r[cnt_r] <= in_data;
            busy_r       <= 1'b1;
            if (cnt_r == '0) begin
              desc_r <= in_desc;
            end
            if (cnt_r == LAST_IDX) begin
              state_r    <= RANK;
              cnt_r      <= '0;
              in_ready_r <= 1'b0;
            end else begin
              cnt_r <= cnt_nx_s;
            end
          end
        end
        RANK: begin
          rank_r[cnt_r] <= rank_s;
          if (cnt_r == LAST_IDX) begin
            state_r <= PLACE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_nx_s;
          end
        end
        PLACE: begin
          // Ranks are a permutation, so each sorted slot is written exactly once.
          for (int i = 0; i < N; i++) begin
            sorted_r[rank_r[i]] <= key_r[i];
            sidx_r[rank_r[i]]   <= IDXW'(i);
          end
          state_r     <= EMIT;
          cnt_r       <= '0;
          out_valid_r <= 1'b1;
          out_data_r  <= first_key_s;
          out_idx_r   <= first_idx_s;
          out_last_r  <= 1'b0;
        end
        EMIT: begin
          if (out_fire_s) begin
            if (out_last_r) begin
              state_r     <= LOAD;
              cnt_r       <= '0;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              in_ready_r  <= 1'b1;
              busy_r      <= 1'b0;
            end else begin
              cnt_r      <= cnt_nx_s;
              out_data_r <= sorted_r[cnt_nx_s];
              out_idx_r  <= sidx_r[cnt_nx_s];
              out_last_r <= (cnt_nx_s == LAST_IDX);
            end
          end
        end
        default: begin
          state_r     <= LOAD;
          cnt_r       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_idx   = out_idx_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;

endmodule
